// File: rtl/traffic_phase_sequencer.sv
// N-phase signal controller: GREEN -> YELLOW -> ALL-RED per served phase, demand-driven selection.
// Define TRAFFIC_FLASH_EN to add the flash input and the flashing-yellow FLASH stage.
module traffic_phase_sequencer #(
  parameter int unsigned NUM_PHASES = 3,
  parameter int unsigned T_GREEN    = 10,
  parameter int unsigned T_YELLOW   = 3,
  parameter int unsigned T_ALLRED   = 2,
  parameter int unsigned T_FLASH    = 8,
  parameter int unsigned SKIP_EMPTY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PHASES-1:0]         req,
`ifdef TRAFFIC_FLASH_EN
  input  logic                          flash,
`endif
  output logic [3*NUM_PHASES-1:0]       lights,
  output logic [$clog2(NUM_PHASES)-1:0] phase_o,
  output logic [1:0]                    stage_o
);

  localparam int unsigned PW    = $clog2(NUM_PHASES);
  localparam int unsigned TMaxA = (T_GREEN > T_YELLOW) ? T_GREEN : T_YELLOW;
  localparam int unsigned TMaxB = (T_ALLRED > T_FLASH) ? T_ALLRED : T_FLASH;
  localparam int unsigned TMax  = (TMaxA > TMaxB) ? TMaxA : TMaxB;
  localparam int unsigned CW    = (TMax > 1) ? $clog2(TMax) : 1;

  localparam logic [2:0] LampRed    = 3'b100;
  localparam logic [2:0] LampYellow = 3'b010;
  localparam logic [2:0] LampGreen  = 3'b001;
  localparam logic [2:0] LampOff    = 3'b000;

  localparam logic [PW-1:0] LastPhase  = PW'(NUM_PHASES - 1);
  localparam logic [CW-1:0] GreenLast  = CW'(T_GREEN - 1);
  localparam logic [CW-1:0] YellowLast = CW'(T_YELLOW - 1);
  localparam logic [CW-1:0] AllRedLast = CW'(T_ALLRED - 1);
`ifdef TRAFFIC_FLASH_EN
  localparam logic [CW-1:0] FlashLast  = CW'(T_FLASH - 1);
`endif

  typedef enum logic [1:0] {
    StGreen  = 2'b00,
    StYellow = 2'b01,
    StAllRed = 2'b10,
    StFlash  = 2'b11
  } stage_e;

  stage_e                  stage_q, stage_d;
  logic [PW-1:0]           phase_q, phase_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    toggle_q, toggle_d;
  logic [3*NUM_PHASES-1:0] lights_q, lights_d;

  logic                    flash_req;
  logic [PW-1:0]           next_phase;
  logic [PW-1:0]           cand;
  logic                    found;

`ifdef TRAFFIC_FLASH_EN
  assign flash_req = flash;
`else
  assign flash_req = 1'b0;
`endif

  // State register; outputs are registered alongside so lamps and stage move on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= StAllRed;
      phase_q  <= LastPhase;
      count_q  <= '0;
      toggle_q <= 1'b0;
      lights_q <= {NUM_PHASES{LampRed}};
    end else begin
      stage_q  <= stage_d;
      phase_q  <= phase_d;
      count_q  <= count_d;
      toggle_q <= toggle_d;
      lights_q <= lights_d;
    end
  end

  // Round-robin search starting after the current phase; the current phase is tried last.
  always_comb begin
    next_phase = PW'((int'(phase_q) + 1) % NUM_PHASES);
    found      = 1'b0;
    cand       = '0;
    if (SKIP_EMPTY != 0) begin
      for (int k = 1; k <= NUM_PHASES; k++) begin
        cand = PW'((int'(phase_q) + k) % NUM_PHASES);
        if (!found && req[cand]) begin
          next_phase = cand;
          found      = 1'b1;
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    stage_d  = stage_q;
    phase_d  = phase_q;
    count_d  = count_q + 1'b1;
    toggle_d = toggle_q;

    if (flash_req && (stage_q != StFlash)) begin
      stage_d  = StFlash;
      count_d  = '0;
      toggle_d = 1'b0;
    end else begin
      unique case (stage_q)
        StGreen: begin
          if (count_q == GreenLast) begin
            stage_d = StYellow;
            count_d = '0;
          end
        end
        StYellow: begin
          if (count_q == YellowLast) begin
            stage_d = StAllRed;
            count_d = '0;
          end
        end
        StAllRed: begin
          if (count_q == AllRedLast) begin
            stage_d = StGreen;
            phase_d = next_phase;
            count_d = '0;
          end
        end
`ifdef TRAFFIC_FLASH_EN
        StFlash: begin
          if (flash_req) begin
            if (count_q == FlashLast) begin
              toggle_d = ~toggle_q;
              count_d  = '0;
            end
          end else begin
            // Leaving flash restarts the search from the top so phase 0 is tried first.
            stage_d  = StAllRed;
            phase_d  = LastPhase;
            count_d  = '0;
            toggle_d = 1'b0;
          end
        end
`endif
        default: begin
          stage_d  = StAllRed;
          phase_d  = LastPhase;
          count_d  = '0;
          toggle_d = 1'b0;
        end
      endcase
    end
  end

  // Lamp pattern for the state being entered.
  always_comb begin
    lights_d = {NUM_PHASES{LampRed}};
    for (int p = 0; p < NUM_PHASES; p++) begin
      unique case (stage_d)
        StGreen: begin
          if (phase_d == PW'(p)) lights_d[3*p +: 3] = LampGreen;
        end
        StYellow: begin
          if (phase_d == PW'(p)) lights_d[3*p +: 3] = LampYellow;
        end
        StFlash: begin
          lights_d[3*p +: 3] = toggle_d ? LampOff : LampYellow;
        end
        default: begin
          lights_d[3*p +: 3] = LampRed;
        end
      endcase
    end
  end

  assign lights  = lights_q;
  assign phase_o = phase_q;
  assign stage_o = stage_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Bench for traffic_phase_sequencer: two instances (skip/rotation timings) checked each cycle
// against a countdown model, plus directed literal checks. Flash tests need TRAFFIC_FLASH_EN.
module tb_traffic_phase_sequencer;

  localparam int N = 3;
`ifdef TRAFFIC_FLASH_EN
  localparam bit FlashEn = 1'b1;
`else
  localparam bit FlashEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_a, rst_b, flash;
  logic [2:0] req_a, req_b;
  logic [8:0] lights_a, lights_b;
  logic [1:0] phase_a, phase_b, stage_a, stage_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_phase_sequencer #(
    .NUM_PHASES(3), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1), .T_FLASH(2), .SKIP_EMPTY(1)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .req(req_a),
`ifdef TRAFFIC_FLASH_EN
    .flash(flash),
`endif
    .lights(lights_a),
    .phase_o(phase_a),
    .stage_o(stage_a)
  );

  traffic_phase_sequencer #(
    .NUM_PHASES(3), .T_GREEN(4), .T_YELLOW(1), .T_ALLRED(1), .T_FLASH(2), .SKIP_EMPTY(0)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .req(req_b),
`ifdef TRAFFIC_FLASH_EN
    .flash(1'b0),
`endif
    .lights(lights_b),
    .phase_o(phase_b),
    .stage_o(stage_b)
  );

  // Model: stage 0 green, 1 yellow, 2 all-red, 3 flash; 'left' counts cycles remaining in stage.
  typedef struct {
    bit valid;
    int stage;
    int phase;
    int left;
    bit off;
  } mdl_t;

  mdl_t ma, mb;

  function automatic int pick(input int p, input logic [2:0] rq, input bit skip);
    if (!skip || rq == 3'b000) return (p + 1) % N;
    for (int k = 1; k <= N; k++) begin
      if (rq[(p + k) % N]) return (p + k) % N;
    end
    return (p + 1) % N;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit fl, input logic [2:0] rq,
                                 input int tg, input int ty, input int ta, input int tf,
                                 input bit skip);
    mdl_t n = m;
    if (r) begin
      n.valid = 1'b1; n.stage = 2; n.phase = N - 1; n.left = ta; n.off = 1'b0;
      return n;
    end
    if (!m.valid) return n;
    if (fl) begin
      if (m.stage != 3) begin
        n.stage = 3; n.left = tf; n.off = 1'b0;
      end else begin
        n.left = m.left - 1;
        if (n.left == 0) begin
          n.off = !m.off; n.left = tf;
        end
      end
      return n;
    end
    if (m.stage == 3) begin
      n.stage = 2; n.phase = N - 1; n.left = ta; n.off = 1'b0;
      return n;
    end
    n.left = m.left - 1;
    if (n.left > 0) return n;
    case (m.stage)
      0: begin n.stage = 1; n.left = ty; end
      1: begin n.stage = 2; n.left = ta; end
      default: begin n.stage = 0; n.left = tg; n.phase = pick(m.phase, rq, skip); end
    endcase
    return n;
  endfunction

  function automatic logic [8:0] mlights(input mdl_t m);
    logic [8:0] v;
    for (int p = 0; p < N; p++) begin
      logic [2:0] l;
      l = 3'b100;
      if (m.stage == 3) l = m.off ? 3'b000 : 3'b010;
      else if (m.stage == 0 && m.phase == p) l = 3'b001;
      else if (m.stage == 1 && m.phase == p) l = 3'b010;
      v[3*p +: 3] = l;
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] cur_stage(input bit b);
    return b ? stage_b : stage_a;
  endfunction

  function automatic int cur_phase(input bit b);
    return b ? int'(phase_b) : int'(phase_a);
  endfunction

  // Waits (at negedges) for a fresh entry into stage st; returns the phase shown then.
  task automatic wait_entry(input bit b, input logic [1:0] st, output int ph);
    logic [1:0] prev;
    prev = cur_stage(b);
    ph = -1;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (cur_stage(b) == st && prev != st) begin
        ph = cur_phase(b);
        return;
      end
      prev = cur_stage(b);
    end
    total++;
    bad++;
    $display("FAIL wait_entry timeout: inst=%0d stage=%0d", b, st);
  endtask

  task automatic wait_entry_phase(input bit b, input logic [1:0] st, input int want);
    int ph;
    for (int i = 0; i < 6; i++) begin
      wait_entry(b, st, ph);
      if (ph == want) return;
    end
    total++;
    bad++;
    $display("FAIL wait_entry_phase timeout: inst=%0d stage=%0d phase=%0d", b, st, want);
  endtask

  task automatic run_len(input bit b, input logic [1:0] st, output int cnt);
    cnt = 0;
    while (cur_stage(b) == st && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    ma = '{default: 0};
    mb = '{default: 0};
  end

  always @(posedge clk) begin
    ma = mstep(ma, rst_a, FlashEn && flash, req_a, 4, 2, 1, 2, 1'b1);
    mb = mstep(mb, rst_b, 1'b0, req_b, 4, 1, 1, 2, 1'b0);
  end

  always @(negedge clk) begin
    if (ma.valid) begin
      chk("a_lights", lights_a, mlights(ma));
      chk("a_stage", stage_a, ma.stage);
      chk("a_phase", phase_a, ma.phase);
    end
    if (mb.valid) begin
      chk("b_lights", lights_b, mlights(mb));
      chk("b_stage", stage_b, mb.stage);
      chk("b_phase", phase_b, mb.phase);
    end
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int ph;
    int cnt;
    rst_a = 1'b1; rst_b = 1'b1; req_a = 3'b000; req_b = 3'b100; flash = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_lights", lights_a, 9'b100100100);
    chk("rst_stage", stage_a, 2'b10);
    chk("rst_phase", phase_a, 2'd2);
    rst_a = 1'b0; rst_b = 1'b0;

    // Rotation with no demand: 0,1,2,0
    for (int i = 0; i < 4; i++) begin
      wait_entry(1'b0, 2'b00, ph);
      chk("t1_rotation", ph, i % 3);
    end
    run_len(1'b0, 2'b00, cnt);
    chk("t1_green_len", cnt, 4);
    run_len(1'b0, 2'b01, cnt);
    chk("t1_yellow_len", cnt, 2);
    run_len(1'b0, 2'b10, cnt);
    chk("t1_allred_len", cnt, 1);

    // Held demand on phase 2 only
    req_a = 3'b100;
    for (int i = 0; i < 3; i++) begin
      wait_entry(1'b0, 2'b00, ph);
      chk("t2_only_phase2", ph, 2);
      chk("t2_lamp", lights_a, 9'b001100100);
    end
    req_a = 3'b000;

    // Request present only in the all-red exit cycle after phase 0 -> skips phase 1
    wait_entry_phase(1'b0, 2'b01, 0);
    wait_entry(1'b0, 2'b10, ph);
    req_a = 3'b100;
    @(negedge clk);
    req_a = 3'b000;
    chk("t3_exit_req_stage", stage_a, 2'b00);
    chk("t3_exit_req_phase", phase_a, 2'd2);

    // Request one cycle too early is ignored -> plain rotation to phase 1, then phase 2
    wait_entry_phase(1'b0, 2'b01, 0);
    @(negedge clk);
    req_a = 3'b100;
    @(negedge clk);
    req_a = 3'b000;
    @(negedge clk);
    chk("t3_early_req_phase", phase_a, 2'd1);
    wait_entry(1'b0, 2'b00, ph);
    chk("t3_after1", ph, 2);

    // Reset on the second green cycle of phase 1
    wait_entry_phase(1'b0, 2'b00, 1);
    @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    chk("t4_lights", lights_a, 9'b100100100);
    chk("t4_stage", stage_a, 2'b10);
    chk("t4_phase", phase_a, 2'd2);
    rst_a = 1'b0;
    wait_entry(1'b0, 2'b00, ph);
    chk("t4_restart", ph, 0);

`ifdef TRAFFIC_FLASH_EN
    wait_entry(1'b0, 2'b01, ph);
    flash = 1'b1;
    @(negedge clk);
    chk("t5_flash_stage", stage_a, 2'b11);
    chk("t5_y1", lights_a, 9'b010010010);
    @(negedge clk);
    chk("t5_y2", lights_a, 9'b010010010);
    @(negedge clk);
    chk("t5_off1", lights_a, 9'b000000000);
    @(negedge clk);
    chk("t5_off2", lights_a, 9'b000000000);
    @(negedge clk);
    chk("t5_y3", lights_a, 9'b010010010);
    flash = 1'b0;
    @(negedge clk);
    chk("t5_exit_stage", stage_a, 2'b10);
    chk("t5_exit_phase", phase_a, 2'd2);
    @(negedge clk);
    chk("t5_resume_stage", stage_a, 2'b00);
    chk("t5_resume_phase", phase_a, 2'd0);
`endif

    // Instance B: short yellow/all-red, fixed rotation despite req=100
    wait_entry_phase(1'b1, 2'b00, 0);
    wait_entry(1'b1, 2'b00, ph);
    chk("t6_rot1", ph, 1);
    wait_entry(1'b1, 2'b00, ph);
    chk("t6_rot2", ph, 2);
    wait_entry(1'b1, 2'b01, ph);
    run_len(1'b1, 2'b01, cnt);
    chk("t6_yellow_len", cnt, 1);
    run_len(1'b1, 2'b10, cnt);
    chk("t6_allred_len", cnt, 1);
    chk("t6_rot3", phase_b, 2'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
